// File: rtl/fp_divider.sv
// fp_divider: sequential FP32 divider, restoring mantissa divide, 1 bit/cycle.
// Define FP_DIVIDER_RNE_EN for round-to-nearest-even; default truncates.
module fp_divider #(
  parameter int EXP_BIAS = 127,
  parameter int QBITS    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_ph;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mb;
  logic [24:0]        r_rem;
  logic [QBITS-1:0]   r_q;
  logic [CW-1:0]      r_cnt;
  logic               r_a_nan, r_a_inf, r_a_zero;
  logic               r_b_nan, r_b_inf, r_b_zero;

  logic               w_ge;
  logic [24:0]        w_sub;
  logic               w_hi;
  logic signed [9:0]  w_exp_adj;
  logic signed [9:0]  w_exp_f;
  logic [22:0]        w_frac;
  logic [31:0]        w_res;
  logic               w_inv;

  assign w_ge  = r_rem >= {1'b0, r_mb};
  assign w_sub = r_rem - {1'b0, r_mb};
  assign w_hi  = r_q[QBITS-1];
  assign w_inv = r_a_nan | r_b_nan |
                 (r_a_zero & r_b_zero) |
                 (r_a_inf & r_b_inf);

  always_comb begin
    w_exp_adj = w_hi ? r_exp : r_exp - 10'sd1;
    w_exp_f   = w_exp_adj;
    w_frac    = '0;
`ifdef FP_DIVIDER_RNE_EN
    begin
      logic [23:0] v_sig;
      logic        v_g, v_s, v_inc;
      logic [24:0] v_sum;
      v_sig = w_hi ? r_q[QBITS-1 -: 24] : r_q[QBITS-2 -: 24];
      v_g   = w_hi ? r_q[QBITS-25] : r_q[QBITS-26];
      v_s   = (w_hi & r_q[QBITS-26]) | (|r_rem);
      v_inc = v_g & (v_s | v_sig[0]);
      v_sum = {1'b0, v_sig} + {24'd0, v_inc};
      // Carry out means the significand rolled over to 1.000...
      if (v_sum[24]) begin
        w_frac  = v_sum[23:1];
        w_exp_f = w_exp_adj + 10'sd1;
      end else begin
        w_frac  = v_sum[22:0];
      end
    end
`else
    w_frac = w_hi ? r_q[QBITS-2 -: 23] : r_q[QBITS-3 -: 23];
`endif
    if (w_exp_f >= 10'sd255)
      w_res = {r_sign, 8'hFF, 23'd0};
    else if (w_exp_f <= 10'sd0)
      w_res = {r_sign, 31'd0};
    else
      w_res = {r_sign, w_exp_f[7:0], w_frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ph        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mb        <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_a_nan     <= 1'b0;
      r_a_inf     <= 1'b0;
      r_a_zero    <= 1'b0;
      r_b_nan     <= 1'b0;
      r_b_inf     <= 1'b0;
      r_b_zero    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= '0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_ph    <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          // Phase 0 splits fields, phase 1 classifies.
          if (!r_ph) begin
            r_ph     <= 1'b1;
            r_sign   <= r_a[31] ^ r_b[31];
            r_exp    <= $signed({2'b00, r_a[30:23]})
                      - $signed({2'b00, r_b[30:23]})
                      + 10'(EXP_BIAS);
            r_rem    <= {1'b0, 1'b1, r_a[22:0]};
            r_mb     <= {1'b1, r_b[22:0]};
            r_a_zero <= r_a[30:23] == 8'h00;
            r_b_zero <= r_b[30:23] == 8'h00;
            r_a_nan  <= (r_a[30:23] == 8'hFF) & (|r_a[22:0]);
            r_b_nan  <= (r_b[30:23] == 8'hFF) & (|r_b[22:0]);
            r_a_inf  <= (r_a[30:23] == 8'hFF) & ~(|r_a[22:0]);
            r_b_inf  <= (r_b[30:23] == 8'hFF) & ~(|r_b[22:0]);
          end else begin
            r_ph    <= 1'b0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_state <= S_DONE;
            if (w_inv) begin
              Q           <= 32'h7FC00000;
              invalid     <= 1'b1;
              div_by_zero <= 1'b0;
            end else if (r_a_inf | r_b_zero) begin
              Q           <= {r_sign, 8'hFF, 23'd0};
              invalid     <= 1'b0;
              div_by_zero <= r_b_zero;
            end else if (r_a_zero | r_b_inf) begin
              Q           <= {r_sign, 31'd0};
              invalid     <= 1'b0;
              div_by_zero <= 1'b0;
            end else begin
              r_state     <= S_DIVIDE;
            end
            if (w_inv | r_a_inf | r_b_zero | r_a_zero | r_b_inf) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_ge ? (w_sub << 1) : (r_rem << 1);
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(QBITS-1))
            r_state <= S_ROUND;
        end
        S_ROUND: begin
          Q           <= w_res;
          invalid     <= 1'b0;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
